// File: rtl/bram_initiator.sv
// Burst read/write master for a single-port BRAM with active-low cs_n/wr_n/rd_n strobes.
// Define BRAM_CLEAR_ON_RESET_EN to zero the whole BRAM after reset before accepting commands.
module bram_initiator #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs_n,
    output logic                  mem_wr_n,
    output logic                  mem_rd_n,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN
`ifdef BRAM_CLEAR_ON_RESET_EN
        , S_CLEAR
`endif
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_next, base_addr, mem_addr_next;
    logic [LEN_WIDTH-1:0]    rem_q, rem_next, base_rem;
    logic [DATA_WIDTH-1:0]   wdata_next;
    logic                    do_wr, do_rd, op_last, rd_go;

    // Read pipeline: stage 1 = strobe on the bus, stage 2 = BRAM output valid.
    logic                    rd_s1, rd_s2, last_s1, last_s2;

    logic [DATA_WIDTH-1:0]   fifo_data [4];
    logic [3:0]              fifo_last;
    logic [1:0]              wptr, rptr;
    logic [2:0]              count, occ;
    logic                    accept, wd_fire, push, pop, room;

    assign accept   = cmd_valid & cmd_ready;
    assign wd_fire  = wd_valid & wd_ready;
    assign busy     = (state != S_IDLE);
    assign rd_valid = (count != 3'd0);
    assign rd_data  = rd_valid ? fifo_data[rptr] : '0;
    assign rd_last  = rd_valid & fifo_last[rptr];
    assign push     = rd_s2;
    assign pop      = rd_valid & rd_ready;
    assign occ      = count + {2'b00, rd_s1} + {2'b00, rd_s2};
    assign room     = (occ < 3'd4);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next    = state;
        addr_next     = addr_q;
        rem_next      = rem_q;
        mem_addr_next = mem_addr;
        wdata_next    = mem_wdata;
        do_wr         = 1'b0;
        do_rd         = 1'b0;
        op_last       = 1'b0;
        rd_go         = 1'b0;
        base_addr     = (state == S_IDLE) ? cmd_addr : addr_q;
        base_rem      = (state == S_IDLE) ? cmd_len  : rem_q;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    addr_next = cmd_addr;
                    rem_next  = cmd_len;
                    if (cmd_wr) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_READ;
                        rd_go      = room;
                    end
                end
            end
            S_WRITE: begin
                if (wd_fire) begin
                    do_wr         = 1'b1;
                    mem_addr_next = addr_q;
                    wdata_next    = wd_data;
                    addr_next     = addr_q + ADDR_ONE;
                    rem_next      = rem_q - LEN_ONE;
                    if (rem_q == '0) state_next = S_IDLE;
                end
            end
            S_READ:  rd_go = room;
            S_DRAIN: if (!rd_s1 && !rd_s2) state_next = S_IDLE;
`ifdef BRAM_CLEAR_ON_RESET_EN
            S_CLEAR: begin
                do_wr         = 1'b1;
                mem_addr_next = addr_q;
                wdata_next    = '0;
                addr_next     = addr_q + ADDR_ONE;
                if (addr_q == '1) state_next = S_IDLE;
            end
`endif
            default: state_next = S_IDLE;
        endcase

        // The first read strobe can go out on the command handshake itself.
        if (rd_go) begin
            do_rd         = 1'b1;
            mem_addr_next = base_addr;
            op_last       = (base_rem == '0);
            addr_next     = base_addr + ADDR_ONE;
            rem_next      = base_rem - LEN_ONE;
            if (base_rem == '0) state_next = S_DRAIN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef BRAM_CLEAR_ON_RESET_EN
            state <= S_CLEAR;
`else
            state <= S_IDLE;
`endif
            addr_q    <= '0;
            rem_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_cs_n  <= 1'b1;
            mem_wr_n  <= 1'b1;
            mem_rd_n  <= 1'b1;
            cmd_ready <= 1'b0;
            wd_ready  <= 1'b0;
            rd_s1     <= 1'b0;
            rd_s2     <= 1'b0;
            last_s1   <= 1'b0;
            last_s2   <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            addr_q    <= addr_next;
            rem_q     <= rem_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= wdata_next;
            mem_cs_n  <= ~(do_wr | do_rd);
            mem_wr_n  <= ~do_wr;
            mem_rd_n  <= ~do_rd;
            cmd_ready <= (state_next == S_IDLE);
            wd_ready  <= (state_next == S_WRITE);
            rd_s1     <= do_rd;
            last_s1   <= op_last;
            rd_s2     <= rd_s1;
            last_s2   <= last_s1;
            if (push) wptr <= wptr + 2'd1;
            if (pop)  rptr <= rptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; the occupancy count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wptr] <= mem_rdata;
            fifo_last[wptr] <= last_s2;
        end
    end

endmodule

// File: tb/tb_bram_initiator.sv
// Self-checking bench for bram_initiator: BRAM model plus a flat reference memory array.
module tb_bram_initiator;
    localparam int AW    = 9;
    localparam int DW    = 8;
    localparam int LW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic          rd_valid, rd_ready, rd_last, busy;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_cs_n, mem_wr_n, mem_rd_n;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    bram_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy),
        .mem_addr(mem_addr), .mem_cs_n(mem_cs_n), .mem_wr_n(mem_wr_n), .mem_rd_n(mem_rd_n),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port BRAM with registered read.
    logic [DW-1:0] bram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    always @(posedge clk) begin
        if (!mem_cs_n && !mem_wr_n) bram[mem_addr] <= mem_wdata;
        if (!mem_cs_n && !mem_rd_n) mem_rdata <= bram[mem_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] wq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, {mem_cs_n, mem_wr_n, mem_rd_n}, 3'b111);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_ready"}, {cmd_ready, wd_ready}, 2'b00);
        check({tag, "_rd"}, {rd_valid, rd_last, rd_data}, 0);
`ifdef BRAM_CLEAR_ON_RESET_EN
        check({tag, "_busy"}, busy, 1);
`else
        check({tag, "_busy"}, busy, 0);
`endif
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input int len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_len   = LW'(len);
        while (!cmd_ready && n < 1000) begin
            tick();
            n++;
        end
        check("cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Data comes from wq when preloaded, random otherwise; alternate=1 drives wd_valid every other cycle.
    task automatic do_write(input logic [AW-1:0] a, input int len, input bit alternate);
        int beat = 0;
        int cyc  = 0;
        int exp_addr;
        logic hs;
        logic [DW-1:0] d;
        send_cmd(1'b1, a, len);
        while (beat <= len && cyc < 200) begin
            wd_valid = alternate ? (cyc % 2 == 0) : ($urandom_range(3) != 0);
            d        = (beat < wq.size()) ? wq[beat] : DW'($urandom);
            wd_data  = d;
            hs       = wd_valid & wd_ready;
            tick();
            cyc++;
            check("wr_strobes", {mem_cs_n, mem_wr_n, mem_rd_n}, hs ? 3'b001 : 3'b111);
            if (hs) begin
                exp_addr = (a + beat) % DEPTH;
                check("wr_addr", mem_addr, exp_addr);
                check("wr_data", mem_wdata, d);
                ref_mem[exp_addr] = d;
                beat++;
            end
        end
        wd_valid = 1'b0;
        wq.delete();
        check("wr_beats", beat, len + 1);
        check("wr_cmd_ready", cmd_ready, 1);
        tick();
        check("wr_release", {mem_cs_n, mem_wr_n}, 2'b11);
    endtask

    // mode 0: rd_ready high after the stall; mode 1: random rd_ready. abort_after >= 0 returns early.
    task automatic do_read(input logic [AW-1:0] a, input int len, input int mode,
                           input int stall, input int abort_after);
        int got_n = 0;
        int cyc = 0;
        int first_valid = -1;
        int stall_strobes = 0;
        int exp_addr;
        bit have_held = 0;
        logic [DW-1:0] held;
        send_cmd(1'b0, a, len);
        while (got_n <= len && cyc < 300) begin
            cyc++;
            if (cyc <= stall)   rd_ready = 1'b0;
            else if (mode == 1) rd_ready = 1'($urandom_range(1));
            else                rd_ready = 1'b1;
            if (cyc <= stall && !mem_cs_n && !mem_rd_n) stall_strobes++;
            if (rd_valid && first_valid < 0) first_valid = cyc;
            if (have_held) check("rd_hold", {rd_valid, rd_data}, {1'b1, held});
            have_held = rd_valid && !rd_ready;
            held      = rd_data;
            if (rd_valid && rd_ready) begin
                exp_addr = (a + got_n) % DEPTH;
                check("rd_data", rd_data, ref_mem[exp_addr]);
                check("rd_last", rd_last, (got_n == len));
                got_n++;
            end
            if (abort_after >= 0 && got_n == abort_after) break;
            tick();
        end
        rd_ready = 1'b0;
        if (abort_after < 0) check("rd_beats", got_n, len + 1);
        if (mode == 0 && stall == 0 && abort_after < 0) begin
            check("rd_latency", first_valid, 3);
            check("rd_stream", cyc, len + 3);
        end
        if (stall > 0) check("rd_stall_strobes", (stall_strobes <= 4), 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bram[i] = DW'(i * 7 + 3);
`ifdef BRAM_CLEAR_ON_RESET_EN
            ref_mem[i] = '0;
`else
            ref_mem[i] = DW'(i * 7 + 3);
`endif
        end
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
        tick();
        check_reset_outputs("por");
        tick();
        rst = 1'b0;
        begin
            int n = 0;
            while (!cmd_ready && n < 2000) begin
                n++;
                tick();
            end
`ifdef BRAM_CLEAR_ON_RESET_EN
            check("clear_cycles", n, DEPTH);
`else
            check("idle_cycles", n, 1);
`endif
        end

`ifdef BRAM_CLEAR_ON_RESET_EN
        do_read(9'h000, 0, 0, 0, -1);
        do_read(9'h1FF, 0, 0, 0, -1);
`endif

        wq = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
        do_write(9'h010, 3, 1'b0);
        do_read(9'h010, 3, 0, 0, -1);

        wq = {8'h11, 8'h22, 8'h33};
        do_write(9'h1FF, 2, 1'b0);
        do_read(9'h1FF, 2, 0, 0, -1);

        do_write(9'h040, 7, 1'b0);
        do_read(9'h040, 7, 0, 10, -1);

        do_write(9'h080, 3, 1'b1);
        do_read(9'h080, 3, 0, 0, -1);

        do_read(9'h040, 7, 0, 0, 2);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        rst = 1'b0;
`ifdef BRAM_CLEAR_ON_RESET_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
        tick();
        check("rst_cmd_ready", cmd_ready, 1);
`endif
        do_read(9'h010, 3, 0, 0, -1);
        do_read(9'h040, 7, 0, 0, -1);

        for (int it = 0; it < 20; it++) begin
            logic [AW-1:0] a;
            int len;
            a   = AW'($urandom_range(DEPTH - 1));
            len = $urandom_range(15);
            do_write(a, len, 1'($urandom_range(1)));
            do_read(a, len, 1, $urandom_range(5), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
